// File: rtl/debounce_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the debounce/event-arbiter slice:
//   chan_state_t  - per-channel state (STABLE / LOCK)
//   MAX_BTNS      - upper bound on the number of button channels
//   lock_cycles() - lockout length in clock cycles, never less than 1
//   id_width()    - width of a channel index, never less than 1
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int MAX_BTNS = 16;

  typedef enum logic {
    STABLE = 1'b0,
    LOCK   = 1'b1
  } chan_state_t;

  function automatic int lock_cycles(input int delay_ns, input int clk_ns);
    int q;
    q = delay_ns / clk_ns;
    return (q < 1) ? 1 : q;
  endfunction

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// debounce_event_arbiter_if
// Valid/ready event stream carrying one debounced button edge per transfer.
//   event_valid - an event is presented (master -> slave)
//   event_ready - slave accepts the presented event (slave -> master)
//   event_id    - channel index of the event, IDW bits
//   event_level - new debounced level, 1 = press, 0 = release
// Modports: master (event producer), slave (event consumer).
// -----------------------------------------------------------------------------
interface debounce_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           event_valid;
  logic           event_ready;
  logic [IDW-1:0] event_id;
  logic           event_level;

  modport master (output event_valid, output event_id, output event_level,
                  input  event_ready);
  modport slave  (input  event_valid, input  event_id, input  event_level,
                  output event_ready);
endinterface

// File: rtl/debounce_event_arbiter_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Early-detection debouncer for one button: reacts on the first edge, then
// ignores the input for LOCK_CYCLES cycles. Optional build macro:
// DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer (reset to 0).
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   btn        - raw button level
//   clear      - the arbiter loaded this channel's event this cycle
//   debounced  - debounced level (registered)
//   pending    - an event for this channel awaits loading (registered)
//   toggle     - combinational strobe: debounced flips at the next edge
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int LOCK_CYCLES = 10,
  parameter int CW          = $clog2(LOCK_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic clear,
  output logic debounced,
  output logic pending,
  output logic toggle
);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic sync1_reg;
  logic sync2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  assign s = sync2_reg;
`else
  assign s = btn;
`endif

  chan_state_t   state_reg;
  logic [CW-1:0] cnt_reg;
  logic          debounced_reg;
  logic          pending_reg;

  // Input is only looked at while STABLE; LOCK masks all bounce.
  assign toggle = (state_reg == STABLE) && (s != debounced_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= STABLE;
      cnt_reg       <= '0;
      debounced_reg <= 1'b0;
      pending_reg   <= 1'b0;
    end else begin
      // A toggle coinciding with a load keeps the flag set: the newer edge
      // still needs its own event.
      pending_reg <= (pending_reg & ~clear) | toggle;
      case (state_reg)
        STABLE: begin
          if (toggle) begin
            debounced_reg <= ~debounced_reg;
            cnt_reg       <= CW'(LOCK_CYCLES - 1);
            state_reg     <= LOCK;
          end
        end
        LOCK: begin
          if (cnt_reg == '0) begin
            state_reg <= STABLE;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        default: state_reg <= STABLE;
      endcase
    end
  end

  assign debounced = debounced_reg;
  assign pending   = pending_reg;

endmodule

// File: rtl/debounce_event_arbiter.sv
// -----------------------------------------------------------------------------
// debounce_event_arbiter
// Debounces N_BTNS buttons and serialises their press/release edges onto one
// valid/ready event stream with a round-robin arbiter.
// Optional build macro: DEBOUNCE_SYNC_EN (2-flop synchronizer per input,
// adds 2 cycles to every latency).
// Ports:
//   clk_i        - clock, rising edge
//   rst_i        - asynchronous active-high reset
//   btn_i        - raw button levels, 1 = pressed
//   debounced_o  - debounced level per channel
//   overrun_o    - sticky: an undelivered event was overwritten
//   ev           - event stream (master side): valid, ready, id, level
// -----------------------------------------------------------------------------
module debounce_event_arbiter
  import debounce_pkg::*;
#(
  parameter int N_BTNS        = 4,
  parameter int CLK_PERIOD_NS = 10,
  parameter int DELAY_NS      = 10_000_000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_BTNS-1:0]        btn_i,
  output logic [N_BTNS-1:0]        debounced_o,
  output logic                     overrun_o,
  debounce_event_arbiter_if.master ev
);

  localparam int LOCK_CYCLES = lock_cycles(DELAY_NS, CLK_PERIOD_NS);
  localparam int CW          = $clog2(LOCK_CYCLES + 1);
  localparam int IDW         = id_width(N_BTNS);

  logic [N_BTNS-1:0] pending_w;
  logic [N_BTNS-1:0] toggle_w;
  logic [N_BTNS-1:0] clear_w;
  logic [IDW-1:0]    grant_w;
  logic              found_w;
  logic              load_w;

  logic              valid_reg;
  logic [IDW-1:0]    id_reg;
  logic              level_reg;
  logic [IDW-1:0]    last_grant_reg;
  logic              overrun_reg;

  generate
    for (genvar gi = 0; gi < N_BTNS; gi++) begin : g_chan
      debounce_channel #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .CW          (CW)
      ) u_chan (
        .clk       (clk_i),
        .rst       (rst_i),
        .btn       (btn_i[gi]),
        .clear     (clear_w[gi]),
        .debounced (debounced_o[gi]),
        .pending   (pending_w[gi]),
        .toggle    (toggle_w[gi])
      );
    end
  endgenerate

  // Round-robin: first pending channel at or after last_grant+1 (mod N).
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    grant_w = '0;
    found_w = 1'b0;
    for (int i = 0; i < N_BTNS; i++) begin
      idx = IDW'((int'(last_grant_reg) + 1 + i) % N_BTNS);
      if (!found_w && pending_w[idx]) begin
        grant_w = idx;
        found_w = 1'b1;
      end
    end
  end

  // The output register refills when empty or as its event is accepted.
  assign load_w = !valid_reg || ev.event_ready;

  always_comb begin
    clear_w = '0;
    if (load_w && found_w) begin
      clear_w[grant_w] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_reg      <= 1'b0;
      id_reg         <= '0;
      level_reg      <= 1'b0;
      last_grant_reg <= IDW'(N_BTNS - 1);
      overrun_reg    <= 1'b0;
    end else begin
      // Overwriting a still-pending event loses an edge; a channel being
      // loaded this cycle has its old event safely captured.
      if (|(toggle_w & pending_w & ~clear_w)) begin
        overrun_reg <= 1'b1;
      end
      if (load_w) begin
        valid_reg <= found_w;
        if (found_w) begin
          id_reg         <= grant_w;
          level_reg      <= debounced_o[grant_w];
          last_grant_reg <= grant_w;
        end
      end
    end
  end

  assign ev.event_valid = valid_reg;
  assign ev.event_id    = id_reg;
  assign ev.event_level = level_reg;
  assign overrun_o      = overrun_reg;

endmodule
